// File: rtl/fft_frame_sequencer_if.sv
// Streaming bundle around the FFT frame sequencer.
//  s_*        : sample stream from the sample FIFO (sequencer is the sink)
//  cfg_*      : config word to the FFT core (sequencer is the source)
//  core_in_*  : sample stream to the FFT core (sequencer is the source)
//  core_out_* : spectrum stream from the FFT core (sequencer is the sink)
//  bin_*      : forwarded low bins to downstream (sequencer is the source)
// modport master = sequencer side, modport slave = FIFO/core/downstream side.
interface fft_frame_sequencer_if #(
   parameter int CFG_W = 24
);
   logic [15:0]      s_tdata;
   logic             s_tvalid;
   logic             s_tready;

   logic [CFG_W-1:0] cfg_tdata;
   logic             cfg_tvalid;
   logic             cfg_tready;

   logic [31:0]      core_in_tdata;
   logic             core_in_tvalid;
   logic             core_in_tready;
   logic             core_in_tlast;

   logic [31:0]      core_out_tdata;
   logic             core_out_tvalid;
   logic             core_out_tready;
   logic             core_out_tlast;

   logic [15:0]      bin_tdata;
   logic             bin_tvalid;
   logic             bin_tready;
   logic             bin_tlast;

   modport master (
      input  s_tdata, s_tvalid,
      output s_tready,
      output cfg_tdata, cfg_tvalid,
      input  cfg_tready,
      output core_in_tdata, core_in_tvalid, core_in_tlast,
      input  core_in_tready,
      input  core_out_tdata, core_out_tvalid, core_out_tlast,
      output core_out_tready,
      output bin_tdata, bin_tvalid, bin_tlast,
      input  bin_tready
   );

   modport slave (
      output s_tdata, s_tvalid,
      input  s_tready,
      input  cfg_tdata, cfg_tvalid,
      output cfg_tready,
      input  core_in_tdata, core_in_tvalid, core_in_tlast,
      output core_in_tready,
      output core_out_tdata, core_out_tvalid, core_out_tlast,
      input  core_out_tready,
      input  bin_tdata, bin_tvalid, bin_tlast,
      output bin_tready
   );
endinterface

// File: rtl/fft_frame_sequencer.sv
// FFT frame sequencer: per frame sends one config word to the FFT core,
// streams NFFT samples (tlast on the last), then drains the spectrum and
// forwards the real part of the lower KEEP_BINS bins. One frame in flight.
//
// Ports
//  sclk, rst        clock, asynchronous active-high reset
//  start            1-cycle pulse, accepted only when idle with n_frames != 0
//  n_frames         number of frames, sampled on an accepted start
//  abort            level; finish the current frame then go idle
//  bus              stream bundle (master side), see fft_frame_sequencer_if
//  busy             sequencer not idle
//  frame_done       1-cycle pulse per completed frame
//  frame_cnt        frames completed since the accepted start (wraps)
//  err_tlast        sticky core tlast mismatch, cleared by an accepted start
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start
// S_CFG   | presenting the config word to the core
// S_FEED  | passing NFFT samples from the FIFO into the core
// S_DRAIN | reading NFFT bins back, forwarding the lower KEEP_BINS
module fft_frame_sequencer #(
   parameter int          NFFT      = 256,
   parameter int          LOG2N     = 8,
   parameter int          KEEP_BINS = 128,
   parameter int          CFG_W     = 24,
   parameter logic [15:0] SCALE_SCH = 16'hAAAA
) (
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [15:0]           n_frames,
   input  logic                  abort,
   fft_frame_sequencer_if.master bus,
   output logic                  busy,
   output logic                  frame_done,
   output logic [15:0]           frame_cnt,
   output logic                  err_tlast
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CFG,
      S_FEED,
      S_DRAIN
   } state_t;

   localparam logic [LOG2N-1:0] LAST_IDX  = LOG2N'(NFFT - 1);
   localparam logic [LOG2N-1:0] KEEP_LAST = LOG2N'(KEEP_BINS - 1);
   // One extra bit so KEEP_BINS == NFFT still compares correctly.
   localparam logic [LOG2N:0]   KEEP_N    = (LOG2N + 1)'(KEEP_BINS);

   state_t            state_q;
   logic [LOG2N-1:0]  samp_cnt_q;
   logic [LOG2N-1:0]  bin_cnt_q;
   logic [15:0]       frames_left_q;
   logic [15:0]       frame_cnt_q;
   logic              cfg_tvalid_q;
   logic              busy_q;
   logic              frame_done_q;
   logic              err_tlast_q;

   logic              in_feed;
   logic              in_drain;
   logic              keep_bin;
   logic              cfg_hs;
   logic              in_hs;
   logic              out_hs;
   logic              bin_at_last;
   logic              unused_core_hi;

   assign in_feed     = (state_q == S_FEED);
   assign in_drain    = (state_q == S_DRAIN);
   assign keep_bin    = ({1'b0, bin_cnt_q} < KEEP_N);
   assign bin_at_last = (bin_cnt_q == LAST_IDX);

   assign cfg_hs = cfg_tvalid_q & bus.cfg_tready;
   assign in_hs  = bus.core_in_tvalid & bus.core_in_tready;
   assign out_hs = bus.core_out_tvalid & bus.core_out_tready;

   // Config word: zero-extended {scale schedule, forward-transform bit}.
   assign bus.cfg_tdata  = {{(CFG_W - 17){1'b0}}, SCALE_SCH, 1'b1};
   assign bus.cfg_tvalid = cfg_tvalid_q;

   // Sample path is a pure passthrough while feeding.
   assign bus.core_in_tdata  = {16'd0, bus.s_tdata};
   assign bus.core_in_tvalid = in_feed & bus.s_tvalid;
   assign bus.s_tready       = in_feed & bus.core_in_tready;
   assign bus.core_in_tlast  = in_feed & (samp_cnt_q == LAST_IDX);

   // Kept bins are flow-controlled by downstream; dropped bins are
   // swallowed at full rate so the core never stalls on them.
   assign bus.bin_tdata       = bus.core_out_tdata[15:0];
   assign bus.bin_tvalid      = in_drain & keep_bin & bus.core_out_tvalid;
   assign bus.bin_tlast       = in_drain & keep_bin & (bin_cnt_q == KEEP_LAST);
   assign bus.core_out_tready = in_drain & (keep_bin ? bus.bin_tready : 1'b1);

   assign unused_core_hi = ^bus.core_out_tdata[31:16];

   assign busy       = busy_q;
   assign frame_done = frame_done_q;
   assign frame_cnt  = frame_cnt_q;
   assign err_tlast  = err_tlast_q;

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         samp_cnt_q    <= '0;
         bin_cnt_q     <= '0;
         frames_left_q <= '0;
         frame_cnt_q   <= '0;
         cfg_tvalid_q  <= 1'b0;
         busy_q        <= 1'b0;
         frame_done_q  <= 1'b0;
         err_tlast_q   <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start && (n_frames != 16'd0)) begin
                  frames_left_q <= n_frames;
                  frame_cnt_q   <= '0;
                  err_tlast_q   <= 1'b0;
                  cfg_tvalid_q  <= 1'b1;
                  busy_q        <= 1'b1;
                  state_q       <= S_CFG;
               end
            end

            S_CFG: begin
               // A handshake in the same cycle as abort commits the frame.
               if (cfg_hs) begin
                  cfg_tvalid_q <= 1'b0;
                  state_q      <= S_FEED;
               end else if (abort) begin
                  cfg_tvalid_q <= 1'b0;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end

            S_FEED: begin
               if (in_hs) begin
                  if (samp_cnt_q == LAST_IDX) begin
                     samp_cnt_q <= '0;
                     state_q    <= S_DRAIN;
                  end else begin
                     samp_cnt_q <= samp_cnt_q + LOG2N'(1);
                  end
               end
            end

            S_DRAIN: begin
               if (out_hs) begin
                  // Core tlast must coincide exactly with the last bin.
                  if (bus.core_out_tlast != bin_at_last) begin
                     err_tlast_q <= 1'b1;
                  end
                  // An early tlast still ends the frame so we resync.
                  if (bus.core_out_tlast || bin_at_last) begin
                     bin_cnt_q     <= '0;
                     frame_done_q  <= 1'b1;
                     frame_cnt_q   <= frame_cnt_q + 16'd1;
                     frames_left_q <= frames_left_q - 16'd1;
                     if ((frames_left_q == 16'd1) || abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                     end else begin
                        cfg_tvalid_q <= 1'b1;
                        state_q      <= S_CFG;
                     end
                  end else begin
                     bin_cnt_q <= bin_cnt_q + LOG2N'(1);
                  end
               end
            end

            default: begin
               cfg_tvalid_q <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;

   logic        sclk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] n_frames;
   logic        abort;
   logic        busy;
   logic        frame_done;
   logic [15:0] frame_cnt;
   logic        err_tlast;

   fft_frame_sequencer_if #(.CFG_W(24)) bus ();

   fft_frame_sequencer #(
      .NFFT(256), .LOG2N(8), .KEEP_BINS(128), .CFG_W(24), .SCALE_SCH(16'hAAAA)
   ) dut (
      .sclk       (sclk),
      .rst        (rst),
      .start      (start),
      .n_frames   (n_frames),
      .abort      (abort),
      .bus        (bus.master),
      .busy       (busy),
      .frame_done (frame_done),
      .frame_cnt  (frame_cnt),
      .err_tlast  (err_tlast)
   );

   always #5 sclk = ~sclk;

   int total = 0;
   int bad   = 0;

   // Scoreboard queues: {tlast, data} for streams, expected frame_cnt for pulses.
   int          exp_cfg[$];
   logic [16:0] exp_in[$];
   logic [16:0] exp_bin[$];
   int          exp_done[$];
   logic [16:0] e_m;
   int          mb = 0;

   task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Monitor: sampled mid-cycle, pops the scoreboard on every handshake.
   always @(negedge sclk) begin
      if (rst) begin
         mb = 0;
      end else begin
         if (bus.cfg_tvalid && bus.cfg_tready) begin
            if (exp_cfg.size() == 0) chk("cfg_unexpected", 40'd1, 40'd0);
            else begin
               void'(exp_cfg.pop_front());
               chk("cfg_tdata", 40'(bus.cfg_tdata), 40'h015555);
            end
         end
         if (bus.core_in_tvalid && bus.core_in_tready) begin
            if (exp_in.size() == 0) chk("in_unexpected", 40'd1, 40'd0);
            else begin
               e_m = exp_in.pop_front();
               chk("core_in", 40'({bus.core_in_tlast, bus.core_in_tdata}),
                   40'({e_m[16], 16'd0, e_m[15:0]}));
            end
         end
         if (bus.core_out_tvalid) begin
            chk("core_out_tready", 40'(bus.core_out_tready),
                40'((mb < 128) ? bus.bin_tready : 1'b1));
            chk("bin_tvalid", 40'(bus.bin_tvalid), 40'((mb < 128) ? 1'b1 : 1'b0));
         end
         if (bus.bin_tvalid && bus.bin_tready) begin
            if (exp_bin.size() == 0) chk("bin_unexpected", 40'd1, 40'd0);
            else begin
               e_m = exp_bin.pop_front();
               chk("bin", 40'({bus.bin_tlast, bus.bin_tdata}), 40'(e_m));
            end
         end
         if (bus.core_out_tvalid && bus.core_out_tready) begin
            if (bus.core_out_tlast || mb == 255) mb = 0;
            else mb++;
         end
         if (frame_done) begin
            if (exp_done.size() == 0) chk("done_unexpected", 40'd1, 40'd0);
            else chk("frame_cnt_at_done", 40'(frame_cnt), 40'(exp_done.pop_front()));
         end
      end
   end

   function automatic bit hs_now(input int w);
      case (w)
         0:       return bus.cfg_tvalid && bus.cfg_tready;
         1:       return bus.core_in_tvalid && bus.core_in_tready;
         default: return bus.core_out_tvalid && bus.core_out_tready;
      endcase
   endfunction

   // Entered just after a rising edge; returns just after the edge that
   // completed the handshake.
   task automatic wait_hs(input int w, input bit stall);
      int n = 0;
      forever begin
         if (stall) bus.bin_tready = ($urandom_range(0, 2) != 0);
         @(negedge sclk);
         if (hs_now(w)) break;
         n++;
         if (n > 2000) begin
            total++;
            bad++;
            $display("FAIL timeout_hs%0d: got no handshake want handshake", w);
            break;
         end
         @(posedge sclk); #1;
      end
      @(posedge sclk); #1;
   endtask

   task automatic tick();
      @(posedge sclk); #1;
   endtask

   task automatic do_start(input int n);
      start    = 1'b1;
      n_frames = 16'(n);
      tick();
      start    = 1'b0;
   endtask

   task automatic run_frame(input int base, input int tlast_bin, input bit stall,
                            input int fc, input int abort_at);
      exp_cfg.push_back(1);
      wait_hs(0, 1'b0);
      start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bus.s_tdata  = 16'(base + i);
         bus.s_tvalid = 1'b1;
         if (i == abort_at) abort = 1'b1;
         exp_in.push_back({(i == 255), 16'(base + i)});
         wait_hs(1, 1'b0);
      end
      bus.s_tvalid = 1'b0;
      exp_done.push_back(fc);
      for (int k = 0; k < 256; k++) begin
         bus.core_out_tdata  = {16'hBEEF ^ 16'(k), 16'(base * 3 + k * 7)};
         bus.core_out_tvalid = 1'b1;
         bus.core_out_tlast  = (k == tlast_bin);
         if (k < 128) exp_bin.push_back({(k == 127), 16'(base * 3 + k * 7)});
         wait_hs(2, stall);
         if (k == tlast_bin) break;
      end
      bus.core_out_tvalid = 1'b0;
      bus.core_out_tlast  = 1'b0;
      bus.bin_tready      = 1'b1;
   endtask

   task automatic idle_chk(input string nm, input int fc, input int err);
      @(negedge sclk);
      chk({nm, "_busy"}, 40'(busy), 40'd0);
      chk({nm, "_frame_cnt"}, 40'(frame_cnt), 40'(fc));
      chk({nm, "_err"}, 40'(err_tlast), 40'(err));
      @(posedge sclk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst                 = 1'b1;
      start               = 1'b0;
      abort               = 1'b0;
      n_frames            = 16'd0;
      bus.s_tdata         = 16'd0;
      bus.s_tvalid        = 1'b0;
      bus.cfg_tready      = 1'b1;
      bus.core_in_tready  = 1'b1;
      bus.core_out_tdata  = 32'd0;
      bus.core_out_tvalid = 1'b0;
      bus.core_out_tlast  = 1'b0;
      bus.bin_tready      = 1'b1;
      repeat (3) @(posedge sclk);
      #1 rst = 1'b0;

      // reset state
      @(negedge sclk);
      chk("rst_busy", 40'(busy), 40'd0);
      chk("rst_frame_cnt", 40'(frame_cnt), 40'd0);
      chk("rst_err", 40'(err_tlast), 40'd0);
      chk("rst_cfg_tvalid", 40'(bus.cfg_tvalid), 40'd0);
      chk("rst_s_tready", 40'(bus.s_tready), 40'd0);
      chk("rst_frame_done", 40'(frame_done), 40'd0);
      tick();

      // 1: reset in the middle of feeding
      do_start(1);
      exp_cfg.push_back(1);
      wait_hs(0, 1'b0);
      for (int i = 0; i < 100; i++) begin
         bus.s_tdata  = 16'(7000 + i);
         bus.s_tvalid = 1'b1;
         exp_in.push_back({1'b0, 16'(7000 + i)});
         wait_hs(1, 1'b0);
      end
      bus.s_tdata         = 16'd123;
      bus.core_out_tvalid = 1'b1;
      rst                 = 1'b1;
      @(negedge sclk);
      chk("mid_rst_busy", 40'(busy), 40'd0);
      chk("mid_rst_s_tready", 40'(bus.s_tready), 40'd0);
      chk("mid_rst_core_in_tvalid", 40'(bus.core_in_tvalid), 40'd0);
      chk("mid_rst_core_out_tready", 40'(bus.core_out_tready), 40'd0);
      chk("mid_rst_cfg_tvalid", 40'(bus.cfg_tvalid), 40'd0);
      chk("mid_rst_bin_tvalid", 40'(bus.bin_tvalid), 40'd0);
      tick();
      rst                 = 1'b0;
      bus.s_tvalid        = 1'b0;
      bus.core_out_tvalid = 1'b0;
      tick();
      do_start(1);
      run_frame(1000, 255, 1'b0, 1, -1);
      idle_chk("t1", 1, 0);

      // 2: two frames, no backpressure
      do_start(2);
      run_frame(0, 255, 1'b0, 1, -1);
      run_frame(256, 255, 1'b0, 2, -1);
      idle_chk("t2", 2, 0);

      // 3: downstream stalls while draining
      do_start(1);
      run_frame(500, 255, 1'b1, 1, -1);
      idle_chk("t3", 1, 0);

      // 4: early core tlast at bin 200, then a normal frame, then clear
      do_start(2);
      run_frame(2000, 200, 1'b0, 1, -1);
      chk("t4_err_set", 40'(err_tlast), 40'd1);
      run_frame(3000, 255, 1'b0, 2, -1);
      idle_chk("t4", 2, 1);
      do_start(1);
      chk("t4_err_clear", 40'(err_tlast), 40'd0);
      run_frame(4000, 255, 1'b0, 1, -1);
      idle_chk("t4b", 1, 0);

      // 5: abort during feed of frame 1 of 3
      do_start(3);
      run_frame(5000, 255, 1'b0, 1, 10);
      idle_chk("t5", 1, 0);
      abort = 1'b0;

      // 5b: abort while config is stalled
      bus.cfg_tready = 1'b0;
      do_start(2);
      chk("t5b_cfg_tvalid", 40'(bus.cfg_tvalid), 40'd1);
      abort = 1'b1;
      tick();
      abort          = 1'b0;
      bus.cfg_tready = 1'b1;
      repeat (3) tick();
      idle_chk("t5b", 0, 0);

      // 6: start with zero frames, then start while busy
      start    = 1'b1;
      n_frames = 16'd0;
      tick();
      start = 1'b0;
      idle_chk("t6_zero", 0, 0);
      do_start(1);
      start    = 1'b1;
      n_frames = 16'd5;
      run_frame(6000, 255, 1'b0, 1, -1);
      idle_chk("t6_busy", 1, 0);
      repeat (3) tick();

      chk("left_cfg", 40'(exp_cfg.size()), 40'd0);
      chk("left_in", 40'(exp_in.size()), 40'd0);
      chk("left_bin", 40'(exp_bin.size()), 40'd0);
      chk("left_done", 40'(exp_done.size()), 40'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
